// File: rtl/if_id_buf_pkg.sv
// Shared types and defaults for the IF/ID fetch buffer: NOP encoding, default widths
// and the fetch packet carried from fetch to decode.
package if_id_buf_pkg;

    localparam int unsigned Addrlen = 32;
    localparam int unsigned Instlen = 32;

    localparam logic [Instlen-1:0] ZeroWord = '0;

    typedef struct packed {
        logic [Addrlen-1:0] pc;
        logic [Instlen-1:0] inst;
        logic               pred;
    } fetch_pkt_t;

    function automatic int unsigned pkt_width(input int unsigned addr_w, input int unsigned inst_w);
        return addr_w + inst_w + 1;
    endfunction

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch/decode handshake bundle for if_id_buf. The master drives fetch inputs, flush and
// decode ready; the slave (the buffer) drives in_ready, the head entry and occupancy.
interface if_id_buf_if
    import if_id_buf_pkg::*;
#(
    parameter int unsigned ADDR_W = Addrlen,
    parameter int unsigned INST_W = Instlen,
    parameter int unsigned DEPTH  = 2
) ();
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_pred;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_pred;
    logic [PTR_W:0]    count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_pred, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_pred, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_pred, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_pred, count
    );

endinterface

// File: rtl/if_id_buf_pipe_fifo_mem.sv
// Depth x Width register array: one synchronous write port and one asynchronous read port.
module if_id_buf_pipe_fifo_mem #(
    parameter int unsigned Width = 65,
    parameter int unsigned Depth = 2
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);
    // Storage is never cleared; validity is tracked by the owner's pointers and count.
    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buf.sv
// IF/ID fetch buffer: DEPTH-entry in-order queue between fetch and decode with redirect flush.
// Defining IF_ID_BUF_STAT_EN adds the saturating stall_cycles counter output.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int unsigned ADDR_W = Addrlen,
    parameter int unsigned INST_W = Instlen,
    parameter int unsigned DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_id_buf_if.slave  bus
`ifdef IF_ID_BUF_STAT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned PktW  = pkt_width(ADDR_W, INST_W);
    localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] hold_pc_q;
    logic              hold_pred_q;

    logic              in_ready, out_valid, push, pop;
    logic [PktW-1:0]   wr_data, rd_data;
    logic [ADDR_W-1:0] head_pc, out_pc;
    logic [INST_W-1:0] head_inst;
    logic              head_pred, out_pred;

    // in_ready looks only at registered occupancy, so a full buffer never passes through.
    assign in_ready  = (count_q != Full) & rst;
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid & in_ready & ~bus.flush;
    assign pop       = out_valid & bus.out_ready & ~bus.flush;

    assign wr_data = {bus.in_pc, bus.in_inst, bus.in_pred};
    assign {head_pc, head_inst, head_pred} = rd_data;

    if_id_buf_pipe_fifo_mem #(
        .Width (PktW),
        .Depth (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_pc_q   <= '0;
            hold_pred_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            hold_pc_q   <= out_pc;
            hold_pred_q <= out_pred;
            if (bus.flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Empty buffer: decode gets a NOP bubble while pc/pred keep their last shown value.
    assign out_pc   = out_valid ? head_pc : hold_pc_q;
    assign out_pred = out_valid ? head_pred : hold_pred_q;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_pc;
    assign bus.out_inst  = out_valid ? head_inst : INST_W'(ZeroWord);
    assign bus.out_pred  = out_pred;
    assign bus.count     = count_q;

`ifdef IF_ID_BUF_STAT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (bus.in_valid && !in_ready && !bus.flush && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Parametrised successor of the IF/ID pipeline latch: a DEPTH-entry in-order buffer between fetch and decode with a valid/ready handshake on both sides.
- Fetch can keep producing while decode stalls, up to DEPTH instructions.
- A flush on a branch or jump redirect kills all buffered entries plus the entry presented that cycle.
- Decode sees a registered head entry and a zero-instruction bubble whenever the buffer is empty.

Parameters:
- ADDR_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- DEPTH, 2, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- flush  in  1  redirect; kill all buffered and incoming entries this cycle.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  buffer can accept this cycle.
- in_pc  in  ADDR_W  fetched PC.
- in_inst  in  INST_W  fetched instruction.
- in_pred  in  1  fetch predicted-taken flag.
- out_valid  out  1  head entry valid to decode.
- out_ready  in  1  decode consumes head this cycle.
- out_pc  out  ADDR_W  head PC.
- out_inst  out  INST_W  head instruction; 0 when out_valid=0.
- out_pred  out  1  head predicted-taken flag.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_pc=0, out_inst=0, out_pred=0, in_ready=0 while held. After release, in_ready=1 from the first edge onward.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- in_ready = (count != DEPTH) & rst. It is a registered-state function; it never depends on out_ready, so there is no pass-through when full.
- Latency: an entry pushed into an empty buffer at edge N has out_valid=1 after edge N. Minimum latency is 1 cycle; throughput is 1 entry/cycle while in_ready=1 and out_ready=1.
- Order is strictly FIFO. Pointers increment modulo DEPTH (natural wrap on PTR_W bits). count += push - pop.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pop when empty: impossible by construction; out_ready ignored while out_valid=0.
- Push when full: in_ready=0, so no write occurs and data is not captured. Fetch must hold its entry.
- Flush (synchronous, highest priority): at the next edge count=0, rd_ptr=wr_ptr, out_valid=0, out_inst=0. The incoming entry is dropped. out_pc keeps its last value. Storage contents are not cleared.
- Flush and reset together: reset wins.
- Outputs: out_pc and out_pred show the head entry. out_inst shows the head instruction when out_valid=1, else 0 (bubble/NOP semantics, as decode expects).
- Payload with out_valid=0 is don't-care except out_inst=0.

Optional Feature:
- Macro IF_ID_BUF_STAT_EN.
- When defined: adds output stall_cycles [31:0]. It increments each cycle in_valid=1 & in_ready=0 & flush=0, saturates at 0xFFFFFFFF, resets to 0 on rst, and is unaffected by flush.
- When undefined: the port and counter are absent and all other behaviour is identical.

Decomposition:
- Shared package/config header holds:
  - ZeroWord / NOP encoding;
  - default ADDR_W and INST_W (Addrlen, Instlen);
  - a packed fetch-packet typedef {pc, inst, pred} used by both sides.
- One natural sub-module is pipe_fifo_mem: a DEPTH x packet register array with write port and async read of rd_ptr. Pointer, count, flush and handshake logic stay in if_id_buf.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> out_valid=0, out_inst=0, count=0, in_ready=1 on the first cycle after release.
- Streaming, DEPTH=2, out_ready=1: push pc 0x0,0x4,0x8 on consecutive cycles -> each appears 1 cycle later in order, count stays <=1.
- Fill/backpressure: out_ready=0, push 0x100 and 0x104 -> count=2 and in_ready=0. Then hold 0x108 valid for 3 cycles -> not accepted. Set out_ready=1 -> outputs 0x100, 0x104, 0x108 in order.
- Flush: with count=2, assert flush alongside in_valid (pc 0x200) -> next cycle count=0, out_valid=0, out_inst=0. 0x200 is never output.
- Wrap-around, DEPTH=4: 10 push/pop cycles with random out_ready -> output order equals input order across pointer wrap, and count is never above 4.
- Stats (IF_ID_BUF_STAT_EN): full buffer with in_valid=1 for 5 cycles -> stall_cycles=5. A flush does not clear it.
